framebuffer_ram: RTL and testbench

Parametrised simple dual-port frame-buffer memory for the VGA pipeline: one write port driven by the drawing logic and one read port driven by the pixel scanner. It adds a registered read-valid flag, write-to-read bypass on address collision, out-of-range address protection, and a hardware clear engine that fills the whole buffer with one colour without drawing-logic involvement.

---
 rtl/framebuffer_ram.sv | 142 ++++++++++++++
 tb/tb_framebuffer_ram.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_ram.sv
`default_nettype none
// ============================================================================
//  Module   : framebuffer_ram
//  Purpose  : Simple dual-port frame-buffer memory for the VGA pipeline.
//             One write port for the drawing logic, one registered read port
//             for the pixel scanner. Write-first bypass on address collision,
//             out-of-range protection, and a hardware clear engine that fills
//             every word with one colour.
//  Revision : 1.0 - initial release
// ============================================================================
module framebuffer_ram #(
  parameter int DATA_W = 3,
  parameter int ADDR_W = 17,
  parameter int DEPTH  = 131072
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              WE,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              RE,
  input  logic [ADDR_W-1:0] rAddr,
  output logic [DATA_W-1:0] dataOut,
  output logic              rValid,
  input  logic              clearReq,
  input  logic [DATA_W-1:0] clearData,
  output logic              busy,
  output logic              clearDone
);

  // Array index width; addresses are range-checked before they reach the array
  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ADDR_ONE  = (ADDR_W+1)'(1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]        state;
  logic [0:0]        state_next;
  // One bit wider than the address so DEPTH == 2**ADDR_W never wraps
  logic [ADDR_W:0]   clr_addr;
  logic [DATA_W-1:0] fill_data;
  logic              clr_last;

  logic              wr_in_range;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_oor;
  logic              collide;

  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] byp_q;
  logic              sel_zero;
  logic              sel_byp;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: start on request, return to idle after the last fill
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (clearReq) state_next = S_CLEAR;
      S_CLEAR: if (clr_last) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs and write-port arbitration: the clear engine owns the port while busy
  always_comb begin
    busy        = (state == S_CLEAR);
    clr_last    = (clr_addr == LAST_ADDR);
    wr_in_range = ({1'b0, wAddr} < DEPTH_EXT);
    rd_oor      = ({1'b0, rAddr} >= DEPTH_EXT);
    if (busy) begin
      wr_en   = !reset;
      wr_addr = clr_addr[ADDR_W-1:0];
      wr_data = fill_data;
    end else begin
      wr_en   = WE && wr_in_range && !reset;
      wr_addr = wAddr;
      wr_data = dataIn;
    end
    collide = wr_en && (wr_addr == rAddr);
    dataOut = sel_zero ? '0 : (sel_byp ? byp_q : ram_q);
  end

  // Plain array with one write and one registered read so it maps to block RAM
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end
    if (RE) begin
      ram_q <= mem[rAddr[IDX_W-1:0]];
    end
  end

  // Read-side select registers: zero for out-of-range/reset, bypass on collision
  always_ff @(posedge clock) begin
    if (reset) begin
      rValid   <= 1'b0;
      sel_zero <= 1'b1;
      sel_byp  <= 1'b0;
    end else begin
      rValid <= RE;
      if (RE) begin
        sel_zero <= rd_oor;
        sel_byp  <= collide;
        byp_q    <= wr_data;
      end
    end
  end

  // Clear engine datapath: capture fill, walk the address, pulse on completion
  always_ff @(posedge clock) begin
    if (reset) begin
      clr_addr  <= '0;
      clearDone <= 1'b0;
    end else begin
      clearDone <= busy && clr_last;
      if ((state == S_IDLE) && clearReq) begin
        clr_addr  <= '0;
        fill_data <= clearData;
      end else if (busy) begin
        clr_addr <= clr_addr + ADDR_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_ram.sv
`default_nettype none
// ============================================================================
//  Module   : tb_framebuffer_ram
//  Purpose  : Self-checking bench for framebuffer_ram. Instance A is a full
//             16-word buffer, instance B a 12-word buffer with unused
//             address space above it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_framebuffer_ram;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Instance A: DEPTH 16
  logic       a_reset, a_we, a_re, a_creq;
  logic [3:0] a_waddr, a_raddr;
  logic [2:0] a_din, a_cdata, a_dout;
  logic       a_rvalid, a_busy, a_done;

  // Instance B: DEPTH 12
  logic       b_reset, b_we, b_re, b_creq;
  logic [3:0] b_waddr, b_raddr;
  logic [2:0] b_din, b_cdata, b_dout;
  logic       b_rvalid, b_busy, b_done;

  framebuffer_ram #(.DATA_W(3), .ADDR_W(4), .DEPTH(16)) u_a (
    .clock(clock), .reset(a_reset), .WE(a_we), .wAddr(a_waddr), .dataIn(a_din),
    .RE(a_re), .rAddr(a_raddr), .dataOut(a_dout), .rValid(a_rvalid),
    .clearReq(a_creq), .clearData(a_cdata), .busy(a_busy), .clearDone(a_done)
  );

  framebuffer_ram #(.DATA_W(3), .ADDR_W(4), .DEPTH(12)) u_b (
    .clock(clock), .reset(b_reset), .WE(b_we), .wAddr(b_waddr), .dataIn(b_din),
    .RE(b_re), .rAddr(b_raddr), .dataOut(b_dout), .rValid(b_rvalid),
    .clearReq(b_creq), .clearData(b_cdata), .busy(b_busy), .clearDone(b_done)
  );

  typedef struct {
    logic       we;
    logic [3:0] wa;
    logic [2:0] wd;
    logic       re;
    logic [3:0] ra;
    logic       ev;
    logic [2:0] ed;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Single read on instance A, checked one cycle later
  task automatic rd_a(input logic [3:0] addr, input logic [2:0] exp, input string name);
    a_re    = 1'b1;
    a_raddr = addr;
    tick();
    a_re    = 1'b0;
    chk({name, "_valid"}, 32'(a_rvalid), 32'd1);
    chk(name, 32'(a_dout), 32'(exp));
  endtask

  task automatic rd_b(input logic [3:0] addr, input logic [2:0] exp, input string name);
    b_re    = 1'b1;
    b_raddr = addr;
    tick();
    b_re    = 1'b0;
    chk({name, "_valid"}, 32'(b_rvalid), 32'd1);
    chk(name, 32'(b_dout), 32'(exp));
  endtask

  task automatic wr_a(input logic [3:0] addr, input logic [2:0] data);
    a_we    = 1'b1;
    a_waddr = addr;
    a_din   = data;
    tick();
    a_we    = 1'b0;
  endtask

  task automatic wr_b(input logic [3:0] addr, input logic [2:0] data);
    b_we    = 1'b1;
    b_waddr = addr;
    b_din   = data;
    tick();
    b_we    = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int done_at;

    //                we    wa     wd      re    ra     ev    ed
    vecs[0]  = '{1'b1, 4'd5,  3'b101, 1'b0, 4'd0,  1'b0, 3'b000};
    vecs[1]  = '{1'b0, 4'd0,  3'b000, 1'b1, 4'd5,  1'b1, 3'b101};
    vecs[2]  = '{1'b0, 4'd0,  3'b000, 1'b0, 4'd5,  1'b0, 3'b101};
    vecs[3]  = '{1'b1, 4'd7,  3'b010, 1'b0, 4'd0,  1'b0, 3'b101};
    vecs[4]  = '{1'b1, 4'd7,  3'b110, 1'b1, 4'd7,  1'b1, 3'b110};
    vecs[5]  = '{1'b0, 4'd0,  3'b000, 1'b1, 4'd7,  1'b1, 3'b110};
    vecs[6]  = '{1'b1, 4'd3,  3'b001, 1'b1, 4'd5,  1'b1, 3'b101};
    vecs[7]  = '{1'b0, 4'd0,  3'b000, 1'b1, 4'd3,  1'b1, 3'b001};
    vecs[8]  = '{1'b1, 4'd0,  3'b011, 1'b1, 4'd3,  1'b1, 3'b001};
    vecs[9]  = '{1'b1, 4'd15, 3'b111, 1'b1, 4'd0,  1'b1, 3'b011};
    vecs[10] = '{1'b0, 4'd0,  3'b000, 1'b1, 4'd15, 1'b1, 3'b111};
    vecs[11] = '{1'b1, 4'd15, 3'b010, 1'b1, 4'd15, 1'b1, 3'b010};

    a_reset = 1'b1; a_we = 1'b0; a_re = 1'b0; a_creq = 1'b0;
    a_waddr = '0;   a_raddr = '0; a_din = '0; a_cdata = '0;
    b_reset = 1'b1; b_we = 1'b0; b_re = 1'b0; b_creq = 1'b0;
    b_waddr = '0;   b_raddr = '0; b_din = '0; b_cdata = '0;
    tick();
    tick();
    a_reset = 1'b0;
    b_reset = 1'b0;

    // Reset state
    chk("rst_dout",   32'(a_dout),   32'd0);
    chk("rst_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst_busy",   32'(a_busy),   32'd0);
    chk("rst_done",   32'(a_done),   32'd0);
    chk("rst_b_dout", 32'(b_dout),   32'd0);

    // Table-driven read/write/collision vectors on instance A
    for (int i = 0; i < 12; i++) begin
      a_we    = vecs[i].we;
      a_waddr = vecs[i].wa;
      a_din   = vecs[i].wd;
      a_re    = vecs[i].re;
      a_raddr = vecs[i].ra;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(a_rvalid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_dout", i),  32'(a_dout),   32'(vecs[i].ed));
    end
    a_we = 1'b0;
    a_re = 1'b0;

    // Out-of-range protection on instance B (DEPTH 12)
    wr_b(4'd11, 3'b101);
    wr_b(4'd1,  3'b110);
    b_we = 1'b1; b_waddr = 4'd13; b_din = 3'b011;
    b_re = 1'b1; b_raddr = 4'd13;
    tick();
    b_we = 1'b0; b_re = 1'b0;
    chk("b_oor_coll_valid", 32'(b_rvalid), 32'd1);
    chk("b_oor_coll_dout",  32'(b_dout),   32'd0);
    rd_b(4'd11, 3'b101, "b_rd11");
    rd_b(4'd14, 3'b000, "b_rd14");
    rd_b(4'd1,  3'b110, "b_rd1");
    rd_b(4'd12, 3'b000, "b_rd12");
    rd_b(4'd11, 3'b101, "b_rd11_after");

    // Preload A with 3'b111 everywhere
    for (int i = 0; i < 16; i++) wr_a(4'(i), 3'b111);

    // Clear with 3'b011, aborted by reset after 6 fill writes
    a_creq = 1'b1; a_cdata = 3'b011;
    tick();
    a_creq = 1'b0; a_cdata = 3'b000;
    chk("abort_busy_start", 32'(a_busy), 32'd1);
    done_cnt = 0;
    for (int k = 1; k <= 6; k++) begin
      a_re    = (k == 3) || (k == 4);
      a_raddr = (k == 3) ? 4'd2 : 4'd10;
      tick();
      if (a_done) done_cnt++;
      if (k == 3) chk("fill_bypass", 32'(a_dout), 32'(3'b011));
      if (k == 4) chk("uncleared_old", 32'(a_dout), 32'(3'b111));
    end
    a_re = 1'b0;
    chk("abort_busy_mid", 32'(a_busy), 32'd1);
    a_reset = 1'b1;
    tick();
    a_reset = 1'b0;
    chk("abort_busy",   32'(a_busy),   32'd0);
    chk("abort_dout",   32'(a_dout),   32'd0);
    chk("abort_rvalid", 32'(a_rvalid), 32'd0);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (a_done || a_busy) done_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    for (int i = 0; i < 16; i++)
      rd_a(4'(i), (i < 6) ? 3'b011 : 3'b111, $sformatf("abort_rd%0d", i));

    // Full clear with 3'b100, a lost external write and an ignored request
    a_creq = 1'b1; a_cdata = 3'b100;
    tick();
    a_creq = 1'b0; a_cdata = 3'b000;
    busy_cnt = a_busy ? 1 : 0;
    done_cnt = 0;
    done_at  = -1;
    for (int c = 1; c <= 20; c++) begin
      a_we    = (c == 8);
      a_waddr = 4'd3;
      a_din   = 3'b001;
      a_creq  = (c == 5);
      tick();
      if (a_busy) busy_cnt++;
      if (a_done) begin
        done_cnt++;
        done_at = c;
      end
    end
    a_we = 1'b0;
    a_creq = 1'b0;
    chk("clr_busy_cycles", 32'(busy_cnt), 32'd16);
    chk("clr_done_count",  32'(done_cnt), 32'd1);
    chk("clr_done_cycle",  32'(done_at),  32'd16);
    chk("clr_busy_end",    32'(a_busy),   32'd0);
    for (int i = 0; i < 16; i++)
      rd_a(4'(i), 3'b100, $sformatf("clr_rd%0d", i));

    // External write works again once idle
    wr_a(4'd3, 3'b001);
    rd_a(4'd3, 3'b001, "post_clr_wr");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
